// File: rtl/bound_max_scheduler_if.sv
// bound_max_scheduler_if: candidate-bank load port, scan control and reduction result of the bound max scheduler.
interface bound_max_scheduler_if #(
    parameter int W  = 8,
    parameter int IW = 3
);
    logic                 load_en;
    logic [IW-1:0]        load_idx;
    logic signed [W-1:0]  load_value;
    logic                 load_act;
    logic                 load_sign;
    logic                 clear;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic signed [W-1:0]  result;
    logic                 result_valid;

    modport master (
        output load_en, load_idx, load_value, load_act, load_sign, clear, start,
        input  busy, done, result, result_valid
    );

    modport slave (
        input  load_en, load_idx, load_value, load_act, load_sign, clear, start,
        output busy, done, result, result_valid
    );
endinterface

// File: rtl/bound_max_scheduler.sv
// bound_max_scheduler: one-comparison-per-cycle signed max over N qualified bounds, emitting the saturated negated maximum.
module bound_max_scheduler #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int IW = 3
) (
    input logic clk,
    input logic reset,
    bound_max_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_nx;
    logic signed [W-1:0] value [N];
    logic [N-1:0]        act, sign;
    logic [IW-1:0]       idx;
    logic signed [W-1:0] acc, neg;
    logic                acc_valid, take;

    assign bus.busy = state != IDLE;

    always_comb begin
        state_nx = state == IDLE ? (bus.start ? SCAN : IDLE)
                 : state == SCAN ? (idx == IW'(N-1) ? DONE : SCAN)
                 : IDLE;
        take = state == SCAN && act[idx] && sign[idx] && (!acc_valid || value[idx] > acc);
        // the most negative value has no positive twin, so it clamps to the largest positive
        neg = acc == {1'b1, {(W-1){1'b0}}} ? {1'b0, {(W-1){1'b1}}} : -acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            acc              <= '0;
            acc_valid        <= 1'b0;
            act              <= '0;
            sign             <= '0;
            for (int i = 0; i < N; i++) value[i] <= '0;
            bus.done         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.done <= state == DONE;
            if (state == IDLE) begin
                idx       <= '0;
                acc       <= '0;
                acc_valid <= 1'b0;
                if (bus.clear) begin
                    act  <= '0;
                    sign <= '0;
                end else if (bus.load_en) begin
                    value[bus.load_idx] <= bus.load_value;
                    act[bus.load_idx]   <= bus.load_act;
                    sign[bus.load_idx]  <= bus.load_sign;
                end
            end
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (take) begin
                    acc       <= value[idx];
                    acc_valid <= 1'b1;
                end
            end
            if (state == DONE) begin
                bus.result       <= acc_valid ? neg : '0;
                bus.result_valid <= acc_valid;
            end
        end
    end
endmodule

// File: tb/tb_bound_max_scheduler.sv
// tb_bound_max_scheduler: directed and randomized checks of bound_max_scheduler against a set-level reference model.
module tb_bound_max_scheduler;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bound_max_scheduler_if #(.W(8), .IW(3)) bus ();
    bound_max_scheduler #(.N(N), .W(8), .IW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the bank is a plain array; a start computes the answer from the set of
    // qualified values at once, and the answer appears after N+2 edges.
    int m_val[N];
    bit m_act[N], m_sgn[N];
    int m_left = 0, m_res = 0, m_pend = 0, m_mx = 0;
    bit m_done = 0, m_valid = 0, m_pvalid = 0, m_any = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_val[i] = 0;
                m_act[i] = 0;
                m_sgn[i] = 0;
            end
            m_left = 0; m_res = 0; m_valid = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done  = 1;
                    m_res   = m_pend;
                    m_valid = m_pvalid;
                end
            end else begin
                if (bus.clear) begin
                    for (int i = 0; i < N; i++) begin
                        m_act[i] = 0;
                        m_sgn[i] = 0;
                    end
                end else if (bus.load_en) begin
                    m_val[bus.load_idx] = $signed(bus.load_value);
                    m_act[bus.load_idx] = bus.load_act;
                    m_sgn[bus.load_idx] = bus.load_sign;
                end
                if (bus.start) begin
                    m_any = 0;
                    m_mx  = 0;
                    for (int i = 0; i < N; i++)
                        if (m_act[i] && m_sgn[i] && (!m_any || m_val[i] > m_mx)) begin
                            m_mx  = m_val[i];
                            m_any = 1;
                        end
                    m_pvalid = m_any;
                    m_pend   = !m_any ? 0 : (-m_mx > 127 ? 127 : -m_mx);
                    m_left   = N + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", bus.busy, m_left > 0);
        check("done", bus.done, m_done);
        check("result", $signed(bus.result), m_res);
        check("result_valid", bus.result_valid, m_valid);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int val, input bit a, input bit s);
        bus.load_en    = 1;
        bus.load_idx   = 3'(idx);
        bus.load_value = 8'(val);
        bus.load_act   = a;
        bus.load_sign  = s;
        tick();
        bus.load_en = 0;
    endtask

    task automatic do_clear();
        bus.clear = 1;
        tick();
        bus.clear = 0;
    endtask

    task automatic run_scan(input string name, input int exp_res, input bit exp_valid);
        int edges, busy_cnt;
        bus.start = 1;
        tick();
        bus.start   = 0;
        bus.load_en = 0;
        bus.clear   = 0;
        edges    = 1;
        busy_cnt = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
        check({name, " done"}, bus.done, 1);
        check({name, " latency"}, edges, N + 2);
        check({name, " busy cycles"}, busy_cnt, N + 1);
        check({name, " result"}, $signed(bus.result), exp_res);
        check({name, " valid"}, bus.result_valid, exp_valid);
    endtask

    int vals[N] = '{5, -3, 12, 7, 0, 0, 0, 0};
    int dones, got;

    initial begin
        bus.load_en = 0; bus.load_idx = 0; bus.load_value = 0; bus.load_act = 0;
        bus.load_sign = 0; bus.clear = 0; bus.start = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset result", $signed(bus.result), 0);
        check("reset valid", bus.result_valid, 0);
        reset = 0;
        tick();

        for (int i = 0; i < N; i++) load(i, vals[i], 1, i < 4);
        run_scan("mixed", -12, 1);

        for (int i = 0; i < N; i++) load(i, vals[i], 1, 0);
        run_scan("no sign", 0, 0);

        do_clear();
        load(6, -128, 1, 1);
        run_scan("saturate", 127, 1);

        do_clear();
        load(2, 50, 1, 1);
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        bus.load_en = 1; bus.load_idx = 2; bus.load_value = 100; bus.load_act = 1; bus.load_sign = 1;
        bus.start = 1;
        tick();
        bus.load_en = 0;
        bus.start   = 0;
        dones = 0;
        got   = 0;
        repeat (20) begin
            if (bus.done) begin
                dones++;
                got = $signed(bus.result);
            end
            tick();
        end
        check("frozen done count", dones, 1);
        check("frozen result", got, -50);
        run_scan("frozen rescan", -50, 1);

        bus.start = 1;
        tick();
        bus.start = 0;
        repeat (3) tick();
        #1 reset = 1;
        #1;
        check("midreset busy", bus.busy, 0);
        check("midreset done", bus.done, 0);
        check("midreset result", $signed(bus.result), 0);
        check("midreset valid", bus.result_valid, 0);
        tick();
        reset = 0;
        run_scan("after reset", 0, 0);

        do_clear();
        load(1, 9, 1, 1);
        load(5, 9, 1, 1);
        load(3, 20, 0, 1);
        run_scan("tie", -9, 1);

        do_clear();
        bus.load_en = 1; bus.load_idx = 4; bus.load_value = 33; bus.load_act = 1; bus.load_sign = 1;
        run_scan("load with start", -33, 1);

        bus.clear = 1;
        bus.load_en = 1; bus.load_idx = 0; bus.load_value = 44; bus.load_act = 1; bus.load_sign = 1;
        run_scan("clear over load", 0, 0);

        for (int c = 0; c < 3000; c++) begin
            bus.load_en    = 1'($urandom_range(0, 1));
            bus.load_idx   = 3'($urandom);
            bus.load_value = $urandom_range(0, 9) == 0 ? 8'h80 : 8'($urandom);
            bus.load_act   = $urandom_range(0, 3) != 0;
            bus.load_sign  = $urandom_range(0, 2) != 0;
            bus.clear      = $urandom_range(0, 39) == 0;
            bus.start      = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1;
                tick();
                reset = 0;
            end else begin
                tick();
            end
        end
        bus.load_en = 0; bus.clear = 0; bus.start = 0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
